// File: rtl/mips_inst_encoder.sv
// Field-level request -> 32-bit MIPS word packer with buffered IMEM writer.
// Optional encode checking is enabled by defining ENCODE_CHECK_EN.
module mips_inst_encoder #(
  parameter int ADDR_W    = 12,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [31:0]       in_abs_target,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    FIN
  } state_t;

  state_t            state;
  logic [31:0]       base;
  logic [ADDR_W-1:0] addr_q [BUF_DEPTH];
  logic [31:0]       data_q [BUF_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [PW:0]       cnt;
  logic              push;
  logic              pop;
  logic [31:0]       pc;
  logic [31:0]       pc4;
  logic [31:0]       off;
  logic [31:0]       word;

  assign pc  = base + {{(29-ADDR_W){1'b0}}, word_count, 2'b00};
  assign pc4 = pc + 32'd4;
  assign off = 32'($signed(in_abs_target - pc4) >>> 2);

  assign in_ready  = (state == RUN) && (cnt != (PW+1)'(BUF_DEPTH));
  assign push      = in_valid && in_ready;
  assign imem_we   = (cnt != '0);
  assign pop       = imem_we && imem_ready;
  assign imem_addr = imem_we ? addr_q[rp] : '0;
  assign imem_din  = imem_we ? data_q[rp] : '0;
  assign done      = (state == FIN);

  always_comb begin
    word = '0;
    unique case (1'b1)
      (in_fmt == 2'b00):
        word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
      (in_fmt == 2'b01):
        word = {in_opcode, in_rs, in_rt, in_imm};
      (in_fmt == 2'b10):
        word = {in_opcode, in_abs_target[27:2]};
      default:
        word = {in_opcode, in_rs, in_rt, off[15:0]};
    endcase
  end

  // Buffer storage needs no reset: cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp] <= pc[ADDR_W+1:2];
      data_q[wp] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      word_count <= '0;
      cnt        <= '0;
      wp         <= '0;
      rp         <= '0;
    end else begin
      if (push) begin
        wp         <= wp + PW'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      if (pop) rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      unique case (state)
        IDLE: if (start) begin
          state      <= RUN;
          base       <= base_addr & 32'hFFFF_FFFC;
          word_count <= '0;
        end
        RUN:   if (push && in_last) state <= FLUSH;
        FLUSH: if (cnt == '0) state <= FIN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENCODE_CHECK_EN
  logic bad;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (in_fmt == 2'b00):
        bad = (in_opcode != 6'd0);
      (in_fmt == 2'b10):
        bad = (in_abs_target[31:28] != pc4[31:28]) ||
              (in_abs_target[1:0] != 2'b00);
      (in_fmt == 2'b11):
        bad = (off[31:15] != {17{off[15]}}) ||
              (in_abs_target[1:0] != 2'b00);
      default:
        bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (push && bad)           err <= 1'b1;
  end
`else
  logic unused_chk;
  assign unused_chk = ^off[31:16];
  assign err = 1'b0;
`endif

endmodule
